// File: rtl/exu_csrfile.sv
// Machine-mode CSR file: combinational reads, edge-committed writes, trap state,
// 64-bit cycle/instret counters and interrupt request generation.
module exu_csrfile #(
    parameter logic [31:0] HARTID    = 32'h0,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_ren,
    input  logic        csr_wen,
    input  logic [11:0] csr_idx,
    input  logic [31:0] csr_wdat,
    output logic [31:0] csr_rdat,
    output logic        csr_ill,
    input  logic        instret_inc,
    input  logic        trap_val,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_val,
    input  logic        irq_sw,
    input  logic        irq_tmr,
    input  logic        irq_ext,
    output logic [31:0] o_mtvec,
    output logic [31:0] o_mepc,
    output logic        o_irq_req,
    output logic [31:0] o_irq_cause
);

    // Interrupt bit vectors are packed as {ext, tmr, sw}.
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [2:0]  ie_q, ie_d, ip_q;
    logic [29:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mscratch_q, mscratch_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [31:0] rd_val;
    logic        impl;
    logic [2:0]  pend;

    always_comb begin
        rd_val = '0;
        impl   = 1'b1;
        case (csr_idx)
            12'h300: rd_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h301: rd_val = 32'h4000_0100;
            12'h304: rd_val = {20'b0, ie_q[2], 3'b0, ie_q[1], 3'b0, ie_q[0], 3'b0};
            12'h305: rd_val = {mtvec_q, 2'b00};
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = {mepc_q, 2'b00};
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'h344: rd_val = {20'b0, ip_q[2], 3'b0, ip_q[1], 3'b0, ip_q[0], 3'b0};
            12'hB00, 12'hC00: rd_val = mcycle_q[31:0];
            12'hB80, 12'hC80: rd_val = mcycle_q[63:32];
            12'hB02, 12'hC02: rd_val = minstret_q[31:0];
            12'hB82, 12'hC82: rd_val = minstret_q[63:32];
            12'hF11, 12'hF12, 12'hF13: rd_val = '0;
            12'hF14: rd_val = HARTID;
            default: impl = 1'b0;
        endcase
    end

    assign csr_rdat = csr_ren ? rd_val : '0;
    assign csr_ill  = (csr_ren | csr_wen) & ~impl;

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        ie_d       = ie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'b0, instret_inc};

        if (csr_wen) begin
            case (csr_idx)
                12'h300: begin
                    mie_d  = csr_wdat[3];
                    mpie_d = csr_wdat[7];
                end
                12'h304: ie_d       = {csr_wdat[11], csr_wdat[7], csr_wdat[3]};
                12'h305: mtvec_d    = csr_wdat[31:2];
                12'h340: mscratch_d = csr_wdat;
                12'h341: mepc_d     = csr_wdat[31:2];
                12'h342: mcause_d   = csr_wdat;
                12'h343: mtval_d    = csr_wdat;
                12'hB00: mcycle_d   = {mcycle_q[63:32], csr_wdat};
                12'hB80: mcycle_d   = {csr_wdat, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], csr_wdat};
                12'hB82: minstret_d = {csr_wdat, minstret_q[31:0]};
                default: ;
            endcase
        end

        // Trap and mret take precedence over a same-cycle CSR write.
        if (trap_val) begin
            mepc_d   = trap_pc[31:2];
            mcause_d = trap_cause;
            mtval_d  = trap_tval;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_val) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            ie_q       <= '0;
            ip_q       <= '0;
            mtvec_q    <= MTVEC_RST[31:2];
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            ie_q       <= ie_d;
            ip_q       <= {irq_ext, irq_tmr, irq_sw};
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign pend        = ip_q & ie_q;
    assign o_irq_req   = mie_q & (|pend);
    assign o_irq_cause = pend[2] ? 32'h8000_000B :
                         pend[0] ? 32'h8000_0003 :
                         pend[1] ? 32'h8000_0007 : 32'h0;
    assign o_mtvec     = {mtvec_q, 2'b00};
    assign o_mepc      = {mepc_q, 2'b00};

endmodule

// File: tb/tb_exu_csrfile.sv
// Directed and randomized checks of exu_csrfile against a masked-register CSR model.
module tb_exu_csrfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_ren = 1'b0, csr_wen = 1'b0;
    logic [11:0] csr_idx = '0;
    logic [31:0] csr_wdat = '0;
    logic [31:0] csr_rdat;
    logic        csr_ill;
    logic        instret_inc = 1'b0;
    logic        trap_val = 1'b0;
    logic [31:0] trap_cause = '0, trap_pc = '0, trap_tval = '0;
    logic        mret_val = 1'b0;
    logic        irq_sw = 1'b0, irq_tmr = 1'b0, irq_ext = 1'b0;
    logic [31:0] o_mtvec, o_mepc, o_irq_cause;
    logic        o_irq_req;

    int n_cmp = 0;
    int n_err = 0;

    exu_csrfile #(.HARTID(32'd5), .MTVEC_RST(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .csr_ren(csr_ren), .csr_wen(csr_wen), .csr_idx(csr_idx),
        .csr_wdat(csr_wdat), .csr_rdat(csr_rdat), .csr_ill(csr_ill), .instret_inc(instret_inc),
        .trap_val(trap_val), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_val(mret_val), .irq_sw(irq_sw), .irq_tmr(irq_tmr), .irq_ext(irq_ext),
        .o_mtvec(o_mtvec), .o_mepc(o_mepc), .o_irq_req(o_irq_req), .o_irq_cause(o_irq_cause)
    );

    always #5 clk = ~clk;

    // Reference state: full 32-bit register images and 64-bit counters.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
    logic [63:0] m_cyc, m_ins;

    task automatic model_reset();
        m_mstatus = 32'h0000_1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
    endtask

    // Returns {implemented, value}.
    function automatic logic [32:0] m_read(logic [11:0] idx);
        case (idx)
            12'h300: return {1'b1, m_mstatus};
            12'h301: return {1'b1, 32'h4000_0100};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, m_mip};
            12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
            12'hF11, 12'hF12, 12'hF13: return {1'b1, 32'h0};
            12'hF14: return {1'b1, 32'd5};
            default: return 33'h0;
        endcase
    endfunction

    function automatic logic [31:0] mwr(logic [31:0] old, logic [31:0] d, logic [31:0] mask);
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [32:0] r;
        logic [31:0] pend, cause;
        r = m_read(csr_idx);
        pend = m_mip & m_mie;
        if (pend[11]) cause = 32'h8000_000B;
        else if (pend[3]) cause = 32'h8000_0003;
        else if (pend[7]) cause = 32'h8000_0007;
        else cause = 0;
        chk("rdat", csr_rdat, csr_ren ? r[31:0] : 32'h0);
        chk("ill", {31'b0, csr_ill}, {31'b0, (csr_ren | csr_wen) & ~r[32]});
        chk("mtvec", o_mtvec, m_mtvec);
        chk("mepc", o_mepc, m_mepc);
        chk("irq_req", {31'b0, o_irq_req}, {31'b0, m_mstatus[3] & (pend != 0)});
        chk("irq_cause", o_irq_cause, cause);
    endtask

    // Check current outputs, advance one clock, and step the model with the applied inputs.
    task automatic tick();
        logic [31:0] n_mstatus, n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval;
        logic [63:0] n_cyc, n_ins;
        #1 check_all();
        n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
        n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
        n_cyc = m_cyc + 1;
        n_ins = m_ins + (instret_inc ? 64'd1 : 64'd0);
        if (csr_wen) begin
            case (csr_idx)
                12'h300: n_mstatus = mwr(m_mstatus, csr_wdat, 32'h88);
                12'h304: n_mie = mwr(m_mie, csr_wdat, 32'h888);
                12'h305: n_mtvec = csr_wdat & ~32'h3;
                12'h340: n_mscratch = csr_wdat;
                12'h341: n_mepc = csr_wdat & ~32'h3;
                12'h342: n_mcause = csr_wdat;
                12'h343: n_mtval = csr_wdat;
                12'hB00: n_cyc = {m_cyc[63:32], csr_wdat};
                12'hB80: n_cyc = {csr_wdat, m_cyc[31:0]};
                12'hB02: n_ins = {m_ins[63:32], csr_wdat};
                12'hB82: n_ins = {csr_wdat, m_ins[31:0]};
                default: ;
            endcase
        end
        if (trap_val) begin
            n_mepc = trap_pc & ~32'h3; n_mcause = trap_cause; n_mtval = trap_tval;
            n_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
        end else if (mret_val) begin
            n_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end
        @(posedge clk);
        m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
        m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval; m_cyc = n_cyc; m_ins = n_ins;
        m_mip = (irq_ext ? 32'h800 : 0) | (irq_tmr ? 32'h80 : 0) | (irq_sw ? 32'h8 : 0);
        #1;
    endtask

    task automatic idle();
        csr_ren = 0; csr_wen = 0; instret_inc = 0; trap_val = 0; mret_val = 0;
    endtask

    task automatic wr(logic [11:0] idx, logic [31:0] d);
        csr_ren = 0; csr_wen = 1; csr_idx = idx; csr_wdat = d;
        tick();
        csr_wen = 0;
    endtask

    // Combinational read within the current cycle, checked against a fixed expectation.
    task automatic rd(string tag, logic [11:0] idx, logic [31:0] exp);
        csr_ren = 1; csr_wen = 0; csr_idx = idx;
        #1 chk(tag, csr_rdat, exp);
        csr_ren = 0;
    endtask

    initial begin
        int unsigned pool [32];
        logic [11:0] p;
        pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                 12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h306, 12'h000,
                 12'hB01, 12'h300, 12'h304, 12'h340, 12'h305, 12'h344, 12'hB00, 12'hB82};
        model_reset();
        #12 rst_n = 1;
        @(posedge clk); #1;

        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("hartid", 12'hF14, 32'd5);
        csr_ren = 1; csr_idx = 12'h7C0;
        #1 chk("unimpl_ill", {31'b0, csr_ill}, 32'd1);
        chk("unimpl_rdat", csr_rdat, 32'h0);
        tick();
        idle();

        wr(12'h305, 32'h8000_0103);
        rd("mtvec_rd", 12'h305, 32'h8000_0100);
        chk("mtvec_out", o_mtvec, 32'h8000_0100);
        csr_wen = 1; csr_idx = 12'h301; csr_wdat = 0;
        #1 chk("misa_wr_ill", {31'b0, csr_ill}, 32'd0);
        tick();
        idle();
        rd("misa", 12'h301, 32'h4000_0100);

        wr(12'h300, 32'h8);
        trap_val = 1; trap_pc = 32'h102; trap_cause = 2; trap_tval = 32'hDEAD;
        tick();
        idle();
        rd("trap_mepc", 12'h341, 32'h100);
        rd("trap_mcause", 12'h342, 32'h2);
        rd("trap_mtval", 12'h343, 32'hDEAD);
        rd("trap_mstatus", 12'h300, 32'h1880);
        mret_val = 1;
        tick();
        idle();
        rd("mret_mstatus", 12'h300, 32'h1888);

        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        rd("carry_hi", 12'hB80, 32'h1);
        rd("carry_lo", 12'hB00, 32'h0);
        instret_inc = 1;
        wr(12'hB02, 32'h77);
        instret_inc = 0;
        rd("minstret_wr", 12'hB02, 32'h77);
        wr(12'hB00, 32'h55);
        rd("mcycle_wr", 12'hB00, 32'h55);
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        rd("wrap_lo", 12'hB00, 32'h0);
        rd("wrap_hi", 12'hB80, 32'h0);

        wr(12'h304, 32'hFFFF_FFFF);
        rd("mie_mask", 12'h304, 32'h888);
        irq_tmr = 1; irq_ext = 1;
        #1 chk("irq_lat0", {31'b0, o_irq_req}, 32'd0);
        tick();
        chk("irq_req", {31'b0, o_irq_req}, 32'd1);
        chk("irq_ext", o_irq_cause, 32'h8000_000B);
        irq_ext = 0;
        tick();
        chk("irq_tmr", o_irq_cause, 32'h8000_0007);

        trap_val = 1; mret_val = 1; csr_wen = 1; csr_idx = 12'h300; csr_wdat = 32'h8;
        trap_pc = 32'h2000; trap_cause = 32'h8000_0007; trap_tval = 0;
        tick();
        idle();
        rd("simul_mstatus", 12'h300, 32'h1880);
        chk("simul_irq_off", {31'b0, o_irq_req}, 32'd0);

        // Reset asserted while a write is pending: the write must be lost.
        csr_wen = 1; csr_idx = 12'h340; csr_wdat = 32'h1234;
        #1 rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        idle(); irq_tmr = 0;
        rst_n = 1;
        rd("rst_mid_wr", 12'h340, 32'h0);
        chk("rst_mepc", o_mepc, 32'h0);
        chk("rst_mtvec", o_mtvec, 32'h0);
        tick();

        for (int i = 0; i < 400; i++) begin
            p = pool[$urandom_range(31)][11:0];
            csr_idx = p;
            csr_ren = 1'($urandom_range(1));
            csr_wen = ($urandom_range(2) == 0);
            csr_wdat = $urandom;
            if (p == 12'hB80 || p == 12'hB82) csr_wdat = 32'($urandom_range(3));
            instret_inc = 1'($urandom_range(1));
            trap_val = ($urandom_range(15) == 0);
            mret_val = ($urandom_range(11) == 0);
            trap_pc = $urandom; trap_cause = $urandom; trap_tval = $urandom;
            irq_sw = ($urandom_range(3) == 0);
            irq_tmr = ($urandom_range(3) == 0);
            irq_ext = ($urandom_range(3) == 0);
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
